// File: rtl/median_stream_filter.sv
// Streaming 3x3 median filter: line buffers, window, 3-stage sorter, output reg.
// Optional macro NOISE_DETECT_EN: only 0/max centre pixels get the median.
module median_stream_filter #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic             clk,
    input  logic             nres,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef logic [PIX_W-1:0] pix_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic          adv;
    logic          acc;
    logic          launch;
    logic          at_end;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    pix_t          lb1_q [IMG_W];
    pix_t          lb2_q [IMG_W];
    pix_t          tap1;
    pix_t          tap2;

    pix_t          win_q [3][3];
    pix_t          win_d [3][3];
    logic          v0_q, v0_d;
    logic          l0_q, l0_d;

    pix_t          s1_q [3][3];
    pix_t          s1_d [3][3];
    logic          v1_q, v1_d;
    logic          l1_q, l1_d;

    pix_t          s2_q [3];
    pix_t          s2_d [3];
    logic          v2_q, v2_d;
    logic          l2_q, l2_d;

    pix_t          m3_q, m3_d;
    logic          v3_q, v3_d;
    logic          l3_q, l3_d;

    pix_t          sel;
    logic          out_valid_q, out_valid_d;
    pix_t          out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    assign adv      = !(out_valid_q && !out_ready);
    assign acc      = in_valid && adv;
    assign in_ready = adv;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;

    assign tap1 = lb1_q[cur_col];
    assign tap2 = lb2_q[cur_col];

    assign launch = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign at_end = (cur_row == ROW_MAX) && (cur_col == COL_MAX);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (acc) begin
            if (cur_col == COL_MAX) begin
                col_d = '0;
                row_d = (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line buffer 1 holds the previous row, line buffer 2 the one before.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[cur_col] <= in_data;
            lb2_q[cur_col] <= tap1;
        end
    end

    always_comb begin
        win_d = win_q;
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = tap2;
            win_d[1][2] = tap1;
            win_d[2][2] = in_data;
        end
    end

    // Sort rows, then max-of-lows / med-of-mids / min-of-highs, then med3.
    always_comb begin
        v0_d = v0_q;
        l0_d = l0_q;
        s1_d = s1_q;
        v1_d = v1_q;
        l1_d = l1_q;
        s2_d = s2_q;
        v2_d = v2_q;
        l2_d = l2_q;
        m3_d = m3_q;
        v3_d = v3_q;
        l3_d = l3_q;
        if (adv) begin
            v0_d = launch;
            l0_d = launch && at_end;
            for (int r = 0; r < 3; r++) begin
                s1_d[r][0] = min2(min2(win_q[r][0], win_q[r][1]),
                                  win_q[r][2]);
                s1_d[r][1] = med3(win_q[r][0], win_q[r][1], win_q[r][2]);
                s1_d[r][2] = max2(max2(win_q[r][0], win_q[r][1]),
                                  win_q[r][2]);
            end
            v1_d = v0_q;
            l1_d = l0_q;
            s2_d[0] = max2(max2(s1_q[0][0], s1_q[1][0]), s1_q[2][0]);
            s2_d[1] = med3(s1_q[0][1], s1_q[1][1], s1_q[2][1]);
            s2_d[2] = min2(min2(s1_q[0][2], s1_q[1][2]), s1_q[2][2]);
            v2_d = v1_q;
            l2_d = l1_q;
            m3_d = med3(s2_q[0], s2_q[1], s2_q[2]);
            v3_d = v2_q;
            l3_d = l2_q;
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            win_q <= '{default: '0};
            v0_q  <= 1'b0;
            l0_q  <= 1'b0;
            s1_q  <= '{default: '0};
            v1_q  <= 1'b0;
            l1_q  <= 1'b0;
            s2_q  <= '{default: '0};
            v2_q  <= 1'b0;
            l2_q  <= 1'b0;
            m3_q  <= '0;
            v3_q  <= 1'b0;
            l3_q  <= 1'b0;
        end else begin
            win_q <= win_d;
            v0_q  <= v0_d;
            l0_q  <= l0_d;
            s1_q  <= s1_d;
            v1_q  <= v1_d;
            l1_q  <= l1_d;
            s2_q  <= s2_d;
            v2_q  <= v2_d;
            l2_q  <= l2_d;
            m3_q  <= m3_d;
            v3_q  <= v3_d;
            l3_q  <= l3_d;
        end
    end

`ifdef NOISE_DETECT_EN
    localparam pix_t PIX_MAX = '1;

    pix_t c1_q, c1_d;
    pix_t c2_q, c2_d;
    pix_t c3_q, c3_d;

    // Centre pixel travels beside the sorter so both arrive together.
    always_comb begin
        c1_d = c1_q;
        c2_d = c2_q;
        c3_d = c3_q;
        if (adv) begin
            c1_d = win_q[1][1];
            c2_d = c1_q;
            c3_d = c2_q;
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
        end else begin
            c1_q <= c1_d;
            c2_q <= c2_d;
            c3_q <= c3_d;
        end
    end

    assign sel = (c3_q == '0 || c3_q == PIX_MAX) ? m3_q : c3_q;
`else
    assign sel = m3_q;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (adv) begin
            out_valid_d = v3_q;
            out_last_d  = v3_q && l3_q;
            if (v3_q) begin
                out_data_d = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_median_stream_filter.sv
// Bench for median_stream_filter on a 5x4 frame; reference model
// recomputes every interior median from a stored frame image.
module tb_median_stream_filter;

    localparam int PIX_W = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
    // Accept sampled before edge k, output sampled after edge k+4.
    localparam int LAT_SAMPLES = 5;

    typedef logic [PIX_W-1:0] pix_t;
    typedef struct packed {
        pix_t d;
        logic l;
    } ob_t;

    logic clk = 1'b0;
    logic nres;
    logic in_valid;
    logic in_ready;
    pix_t in_data;
    logic in_sof;
    logic out_valid;
    logic out_ready;
    pix_t out_data;
    logic out_last;

    median_stream_filter #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk      (clk),
        .nres     (nres),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   launch_cyc = -1;
    int   ov_cyc = -1;
    ob_t  exp_q[$];
    ob_t  got_q[$];
    pix_t img[IMG_H][IMG_W];
    pix_t frm[IMG_H][IMG_W];
    int   mrow = 0;
    int   mcol = 0;
    int   ramp_exp[NOUT] = '{6, 7, 8, 11, 12, 13};

    task automatic model_accept(input pix_t d, input logic s);
        pix_t v[$];
        ob_t  o;
        if (s) begin
            mrow = 0;
            mcol = 0;
        end
        img[mrow][mcol] = d;
        if (mrow >= 2 && mcol >= 2) begin
            for (int r = mrow - 2; r <= mrow; r++)
                for (int c = mcol - 2; c <= mcol; c++)
                    v.push_back(img[r][c]);
            v.sort();
            o.d = v[4];
`ifdef NOISE_DETECT_EN
            if (img[mrow-1][mcol-1] != 8'd0 &&
                img[mrow-1][mcol-1] != 8'd255)
                o.d = img[mrow-1][mcol-1];
`endif
            o.l = (mrow == IMG_H - 1) && (mcol == IMG_W - 1);
            exp_q.push_back(o);
            if (launch_cyc < 0) launch_cyc = cyc;
        end
        mcol++;
        if (mcol == IMG_W) begin
            mcol = 0;
            mrow++;
            if (mrow == IMG_H) mrow = 0;
        end
    endtask

    task automatic model_reset();
        mrow = 0;
        mcol = 0;
        exp_q.delete();
        got_q.delete();
        launch_cyc = -1;
        ov_cyc = -1;
    endtask

    task automatic cycle(input logic v, input pix_t d, input logic s,
                         input logic r, output bit a);
        ob_t o;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_sof    = s;
        out_ready = r;
        #1;
        cyc++;
        if (out_valid && ov_cyc < 0) ov_cyc = cyc;
        if (out_valid && out_ready) begin
            o.d = out_data;
            o.l = out_last;
            got_q.push_back(o);
        end
        a = in_valid && in_ready;
        if (a) model_accept(d, s);
    endtask

    task automatic send_frame(input bit sof, input int vpct, input int rpct);
        int   idx = 0;
        int   guard = 0;
        bit   a;
        logic v;
        logic r;
        while (idx < NPIX && guard < 1000) begin
            v = ($urandom_range(99) < vpct);
            r = ($urandom_range(99) < rpct);
            cycle(v, frm[idx/IMG_W][idx%IMG_W], v && sof && idx == 0, r, a);
            if (a) idx++;
            guard++;
        end
        if (idx < NPIX) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: sent %0d required %0d", idx, NPIX);
        end
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1, a);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                frm[r][c] = pix_t'(5 * r + c);
    endtask

    task automatic fill_const(input pix_t val);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                frm[r][c] = val;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                case ($urandom_range(3))
                    0: frm[r][c] = 8'd0;
                    1: frm[r][c] = 8'd255;
                    default: frm[r][c] = pix_t'($urandom_range(255));
                endcase
    endtask

    task automatic test_reset();
        nres = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_sof = 1'b0;
        out_ready = 1'b1;
        #2;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid: got %b required 0", out_valid);
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_err++;
            $display("FAIL rst_data: got %0d required 0", out_data);
        end
        n_cmp++;
        if (out_last !== 1'b0) begin
            n_err++;
            $display("FAIL rst_last: got %b required 0", out_last);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ready: got %b required 1", in_ready);
        end
        repeat (2) @(negedge clk);
        nres = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst: got ready=%b valid=%b required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_ramp();
        model_reset();
        fill_ramp();
        send_frame(1'b1, 100, 100);
        drain();
        n_cmp++;
        if (got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL ramp_count: got %0d required %0d", got_q.size(), NOUT);
        end
        for (int i = 0; i < got_q.size() && i < NOUT; i++) begin
            n_cmp++;
            if (got_q[i].d !== pix_t'(ramp_exp[i]) ||
                got_q[i].l !== (i == NOUT - 1)) begin
                n_err++;
                $display("FAIL ramp_out[%0d]: got d=%0d l=%b required d=%0d l=%b",
                         i, got_q[i].d, got_q[i].l, ramp_exp[i], i == NOUT - 1);
            end
        end
        n_cmp++;
        if (ov_cyc - launch_cyc != LAT_SAMPLES) begin
            n_err++;
            $display("FAIL ramp_latency: got %0d required %0d",
                     ov_cyc - launch_cyc, LAT_SAMPLES);
        end
    endtask

    task automatic test_salt();
        model_reset();
        fill_const(8'd50);
        frm[1][2] = 8'd255;
        frm[2][1] = 8'd0;
        send_frame(1'b1, 100, 100);
        drain();
        n_cmp++;
        if (got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL salt_count: got %0d required %0d", got_q.size(), NOUT);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== 8'd50) begin
                n_err++;
                $display("FAIL salt_out[%0d]: got %0d required 50", i, got_q[i].d);
            end
        end
    endtask

    task automatic test_backpressure();
        int   idx = 0;
        int   stall = 0;
        int   guard = 0;
        bit   seen = 0;
        bit   a;
        logic v;
        pix_t held = '0;
        model_reset();
        fill_ramp();
        while ((idx < NPIX || stall > 0) && guard < 200) begin
            v = (idx < NPIX);
            cycle(v, v ? frm[idx/IMG_W][idx%IMG_W] : '0,
                  v && idx == 0, stall == 0, a);
            if (a) idx++;
            if (stall > 0) begin
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_stall: got ready=%b valid=%b required 0/1",
                             in_ready, out_valid);
                end
                if (stall == 5) begin
                    held = out_data;
                end else begin
                    n_cmp++;
                    if (out_data !== held) begin
                        n_err++;
                        $display("FAIL bp_hold: got %0d required %0d",
                                 out_data, held);
                    end
                end
                stall--;
            end else if (!seen && out_valid) begin
                seen = 1;
                stall = 5;
            end
            guard++;
        end
        drain();
        n_cmp++;
        if (!seen || got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL bp_count: got %0d (stalled=%b) required %0d",
                     got_q.size(), seen, NOUT);
        end
        for (int i = 0; i < got_q.size() && i < NOUT; i++) begin
            n_cmp++;
            if (got_q[i].d !== pix_t'(ramp_exp[i])) begin
                n_err++;
                $display("FAIL bp_out[%0d]: got %0d required %0d",
                         i, got_q[i].d, ramp_exp[i]);
            end
        end
    endtask

    task automatic test_resync();
        bit a;
        model_reset();
        for (int i = 0; i < 7; i++)
            cycle(1'b1, pix_t'($urandom_range(255)), 1'b0, 1'b1, a);
        fill_ramp();
        send_frame(1'b1, 100, 100);
        drain();
        n_cmp++;
        if (got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL resync_count: got %0d required %0d", got_q.size(), NOUT);
        end
        for (int i = 0; i < got_q.size() && i < NOUT; i++) begin
            n_cmp++;
            if (got_q[i].d !== pix_t'(ramp_exp[i])) begin
                n_err++;
                $display("FAIL resync_out[%0d]: got %0d required %0d",
                         i, got_q[i].d, ramp_exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        bit a;
        model_reset();
        fill_rand();
        while (!out_valid && idx < NPIX) begin
            cycle(1'b1, frm[idx/IMG_W][idx%IMG_W], idx == 0, 1'b0, a);
            if (a) idx++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre: got valid=%b required 1", out_valid);
        end
        nres = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_async: got valid=%b ready=%b required 0/1",
                     out_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        nres = 1'b1;
        model_reset();
        fill_rand();
        send_frame(1'b0, 100, 100);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size() || exp_q.size() != NOUT) begin
            n_err++;
            $display("FAIL rmid_count: got %0d required %0d", got_q.size(), NOUT);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rmid_out[%0d]: got d=%0d l=%b required d=%0d l=%b",
                         i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
    endtask

    task automatic test_noise();
        pix_t want;
`ifdef NOISE_DETECT_EN
        want = 8'd100;
`else
        want = 8'd0;
`endif
        model_reset();
        fill_const(8'd0);
        frm[1][1] = 8'd100;
        send_frame(1'b1, 100, 100);
        drain();
        n_cmp++;
        if (got_q.size() == 0 || got_q[0].d !== want) begin
            n_err++;
            $display("FAIL noise_keep: got %0d required %0d",
                     got_q.size() > 0 ? got_q[0].d : 8'hxx, want);
        end
        model_reset();
        fill_const(8'd40);
        frm[1][1] = 8'd255;
        send_frame(1'b1, 100, 100);
        drain();
        n_cmp++;
        if (got_q.size() == 0 || got_q[0].d !== 8'd40) begin
            n_err++;
            $display("FAIL noise_salt: got %0d required 40",
                     got_q.size() > 0 ? got_q[0].d : 8'hxx);
        end
    endtask

    task automatic test_random();
        model_reset();
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            send_frame(1'($urandom_range(1)), 70, 60);
        end
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 4 * NOUT) begin
            n_err++;
            $display("FAIL rand_count: got %0d required %0d",
                     got_q.size(), 4 * NOUT);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got d=%0d l=%b required d=%0d l=%b",
                         i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_salt();
        test_backpressure();
        test_resync();
        test_reset_mid();
        test_noise();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
